// File: rtl/pic_pkg.sv
// Shared encodings, FSM states and command-word bit positions for the PIC command sequencer.
// Pure declarations: no logic, no latency, no flow control.
package pic_pkg;

  typedef enum logic [2:0] {
    WC_ICW1 = 3'd0,
    WC_ICW2 = 3'd1,
    WC_ICW3 = 3'd2,
    WC_ICW4 = 3'd3,
    WC_OCW1 = 3'd4,
    WC_OCW2 = 3'd5,
    WC_OCW3 = 3'd6
  } wr_word_e;

  typedef enum logic [2:0] {
    ST_UNINIT,
    ST_W_ICW2,
    ST_W_ICW3,
    ST_W_ICW4,
    ST_READY
  } state_e;

  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;
  localparam int CMD_D4    = 4;
  localparam int CMD_D3    = 3;
  localparam int ICW4_SFNM = 4;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_AEOI = 1;
  localparam int OCW3_EXT  = 7;
  localparam int OCW3_ESMM = 6;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_P    = 2;
  localparam int OCW3_RR   = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pic_bus_sync.sv
// Synchronises the CPU bus pins and detects write-commit / read strobe edges.
// Edges appear SYNC_STAGES cycles after the pin edge; no backpressure, the CPU paces itself.
module pic_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       wr_commit,
  output logic       rd_edge,
  output logic       a0_cap,
  output logic [7:0] din_cap
);

  // Bit layout {cs_n, rd_n, wr_n, a0, din}; idle has the strobes high.
  localparam logic [11:0] IDLE = 12'hE00;

  logic [11:0] sync_q [SYNC_STAGES];
  logic [11:0] s;
  logic        wr_q, rd_q, cap_cs;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      cap_cs  <= 1'b0;
      a0_cap  <= 1'b0;
      din_cap <= 8'h00;
    end else begin
      sync_q[0] <= {cs_n, rd_n, wr_n, a0, din};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wr_q <= s[9];
      rd_q <= s[10];
      // The write is tracked for its whole low phase; data only loads while selected.
      if (!s[9]) begin
        cap_cs <= !s[11];
        if (!s[11]) {a0_cap, din_cap} <= s[8:0];
      end
    end
  end

  assign wr_commit = s[9] && !wr_q && cap_cs;
  assign rd_edge   = !s[10] && rd_q && !s[11];

endmodule

// File: rtl/pic_cmd_sequencer.sv
// PIC command-word front end: ICW1..4 sequencing, OCW1..3 decode, config/mask registers.
// Outputs update SYNC_STAGES+1 cycles after the wr_n/rd_n pin edge; no backpressure.
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter int IRQ_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MASK_BYTES  = IRQ_W / 8,
  parameter int LVL_W       = clog2(IRQ_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic             a0,
  input  logic [7:0]       din,
  output logic [2:0]       wr_cur,
  output logic             wr_stb,
  output logic             rd_stb,
  output logic             init_done,
  output logic             ltim,
  output logic             sngl,
  output logic             ic4,
  output logic [4:0]       vec_base,
  output logic [7:0]       icw3,
  output logic             aeoi,
  output logic             sfnm,
  output logic             buf_en,
  output logic             ms,
  output logic [IRQ_W-1:0] imr,
  output logic             ocw2_stb,
  output logic [2:0]       ocw2_cmd,
  output logic [LVL_W-1:0] ocw2_lvl,
  output logic [1:0]       rd_sel,
  output logic             poll_stb,
  output logic             smm,
  output logic             seq_err
);

  localparam int BP_W     = (MASK_BYTES > 1) ? clog2(MASK_BYTES) : 1;
  localparam bit HAS_PAGE = (IRQ_W > 8);

  logic             wr_commit, rd_edge, a0_cap;
  logic [7:0]       d;
  state_e           state, state_nxt;
  wr_word_e         word;
  logic             commit, err, last_byte;
  logic [BP_W-1:0]  bp;
  logic [7:0]       staging [MASK_BYTES];
  logic [IRQ_W-1:0] imr_new;
  // Page pre-shifted into the upper level bits, so the low three bits stay zero.
  logic [LVL_W-1:0] page_lvl;

  pic_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0), .din(din),
    .wr_commit(wr_commit), .rd_edge(rd_edge), .a0_cap(a0_cap), .din_cap(d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_UNINIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    word      = WC_ICW1;
    commit    = 1'b0;
    err       = 1'b0;
    if (wr_commit) begin
      if (!a0_cap && d[CMD_D4]) begin
        commit    = 1'b1;
        state_nxt = ST_W_ICW2;
      end else begin
        case (state)
          ST_W_ICW2: if (a0_cap) begin
            commit    = 1'b1;
            word      = WC_ICW2;
            state_nxt = !sngl ? ST_W_ICW3 : (ic4 ? ST_W_ICW4 : ST_READY);
          end else err = 1'b1;
          ST_W_ICW3: if (a0_cap) begin
            commit    = 1'b1;
            word      = WC_ICW3;
            state_nxt = ic4 ? ST_W_ICW4 : ST_READY;
          end else err = 1'b1;
          ST_W_ICW4: if (a0_cap) begin
            commit    = 1'b1;
            word      = WC_ICW4;
            state_nxt = ST_READY;
          end else err = 1'b1;
          ST_READY: begin
            if (a0_cap) begin
              commit = 1'b1;
              word   = WC_OCW1;
            end else if (!d[CMD_D3]) begin
              commit = 1'b1;
              word   = WC_OCW2;
            end else if (d[OCW3_EXT] && !HAS_PAGE) begin
              err = 1'b1;
            end else begin
              commit = 1'b1;
              word   = WC_OCW3;
            end
          end
          default: err = 1'b1;
        endcase
      end
    end
  end

  assign last_byte = (bp == BP_W'(MASK_BYTES - 1));

  always_comb begin
    imr_new = imr;
    for (int i = 0; i < MASK_BYTES; i++)
      imr_new[i*8 +: 8] = (BP_W'(i) == bp) ? d : staging[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cur <= 3'd0; wr_stb <= 1'b0; rd_stb <= 1'b0; init_done <= 1'b0;
      ltim <= 1'b0; sngl <= 1'b0; ic4 <= 1'b0; vec_base <= 5'd0; icw3 <= 8'd0;
      aeoi <= 1'b0; sfnm <= 1'b0; buf_en <= 1'b0; ms <= 1'b0;
      imr <= '1; ocw2_stb <= 1'b0; ocw2_cmd <= 3'd0; ocw2_lvl <= '0;
      rd_sel <= 2'b00; poll_stb <= 1'b0; smm <= 1'b0; seq_err <= 1'b0;
      bp <= '0; page_lvl <= '0;
      for (int i = 0; i < MASK_BYTES; i++) staging[i] <= 8'h00;
    end else begin
      wr_stb   <= commit;
      rd_stb   <= rd_edge;
      seq_err  <= err;
      ocw2_stb <= 1'b0;
      poll_stb <= 1'b0;
      if (commit) begin
        wr_cur <= word;
        if (!a0_cap) bp <= '0;
        if (state_nxt == ST_READY && state != ST_READY) init_done <= 1'b1;
        case (word)
          WC_ICW1: begin
            ltim <= d[ICW1_LTIM]; sngl <= d[ICW1_SNGL]; ic4 <= d[ICW1_IC4];
            imr <= '0; smm <= 1'b0; rd_sel <= 2'b10; page_lvl <= '0; init_done <= 1'b0;
          end
          WC_ICW2: begin
            vec_base <= d[7:3];
            if (state_nxt == ST_READY) begin
              aeoi <= 1'b0; sfnm <= 1'b0; buf_en <= 1'b0; ms <= 1'b0;
            end
          end
          WC_ICW3: begin
            icw3 <= d;
            if (state_nxt == ST_READY) begin
              aeoi <= 1'b0; sfnm <= 1'b0; buf_en <= 1'b0; ms <= 1'b0;
            end
          end
          WC_ICW4: begin
            aeoi <= d[ICW4_AEOI]; sfnm <= d[ICW4_SFNM]; buf_en <= d[ICW4_BUF]; ms <= d[ICW4_MS];
          end
          WC_OCW1: begin
            if (last_byte) begin
              imr <= imr_new;
              bp  <= '0;
            end else begin
              staging[bp] <= d;
              bp          <= bp + 1'b1;
            end
          end
          WC_OCW2: begin
            ocw2_cmd <= d[7:5];
            ocw2_lvl <= page_lvl | LVL_W'(d[2:0]);
            ocw2_stb <= 1'b1;
          end
          WC_OCW3: begin
            if (d[OCW3_EXT]) begin
              page_lvl <= d[LVL_W-1:0] << 3;
            end else begin
              if (d[OCW3_RR])   rd_sel <= d[1:0];
              if (d[OCW3_P])    poll_stb <= 1'b1;
              if (d[OCW3_ESMM]) smm <= d[OCW3_SMM];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed bench for pic_cmd_sequencer with a 16-line configuration (two OCW1 bytes, 1-bit page).
// Each write records strobe counts and the cycle of the wr_stb pulse after the wr_n rising edge.
module tb_pic_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst, cs_n, rd_n, wr_n, a0;
  logic [7:0]  din;
  logic [2:0]  wr_cur;
  logic        wr_stb, rd_stb, init_done, ltim, sngl, ic4;
  logic [4:0]  vec_base;
  logic [7:0]  icw3;
  logic        aeoi, sfnm, buf_en, ms;
  logic [15:0] imr;
  logic        ocw2_stb;
  logic [2:0]  ocw2_cmd;
  logic [3:0]  ocw2_lvl;
  logic [1:0]  rd_sel;
  logic        poll_stb, smm, seq_err;

  int checks = 0;
  int failures = 0;
  int stb_cyc, n_wr, n_err, n_o2, n_poll, n_rd;

  always #5 clk = ~clk;

  pic_cmd_sequencer #(.IRQ_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0), .din(din),
    .wr_cur(wr_cur), .wr_stb(wr_stb), .rd_stb(rd_stb), .init_done(init_done),
    .ltim(ltim), .sngl(sngl), .ic4(ic4), .vec_base(vec_base), .icw3(icw3),
    .aeoi(aeoi), .sfnm(sfnm), .buf_en(buf_en), .ms(ms), .imr(imr),
    .ocw2_stb(ocw2_stb), .ocw2_cmd(ocw2_cmd), .ocw2_lvl(ocw2_lvl), .rd_sel(rd_sel),
    .poll_stb(poll_stb), .smm(smm), .seq_err(seq_err)
  );

  task automatic do_reset();
    rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wr_word(input logic a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    stb_cyc = 0; n_wr = 0; n_err = 0; n_o2 = 0; n_poll = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (wr_stb) begin n_wr++; if (stb_cyc == 0) stb_cyc = k; end
      if (seq_err)  n_err++;
      if (ocw2_stb) n_o2++;
      if (poll_stb) n_poll++;
    end
    cs_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imr !== 16'hFFFF) begin failures++; $display("FAIL reset_imr got=%h want=ffff", imr); end
    checks++; if ({init_done, wr_stb, seq_err, ocw2_stb, poll_stb, smm} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=000000", {init_done, wr_stb, seq_err, ocw2_stb, poll_stb, smm}); end
    checks++; if ({wr_cur, rd_sel, vec_base, icw3} !== 18'h0) begin
      failures++; $display("FAIL reset_regs got=%h want=0", {wr_cur, rd_sel, vec_base, icw3}); end
  endtask

  task automatic test_init_single();
    wr_word(1'b0, 8'h13);
    checks++; if ({ltim, sngl, ic4} !== 3'b011) begin failures++; $display("FAIL icw1_fields got=%b want=011", {ltim, sngl, ic4}); end
    checks++; if (imr !== 16'h0000 || rd_sel !== 2'b10) begin failures++; $display("FAIL icw1_clear imr=%h rd_sel=%b want 0000/10", imr, rd_sel); end
    wr_word(1'b1, 8'h40);
    checks++; if (vec_base !== 5'h08 || wr_cur !== 3'd1) begin failures++; $display("FAIL icw2 vec=%h cur=%0d want 08/1", vec_base, wr_cur); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL icw2_wait_icw4 init_done=%b want 0", init_done); end
    wr_word(1'b1, 8'h03);
    checks++; if ({aeoi, sfnm, buf_en, ms} !== 4'b1000) begin failures++; $display("FAIL icw4_fields got=%b want=1000", {aeoi, sfnm, buf_en, ms}); end
    checks++; if (init_done !== 1'b1 || wr_cur !== 3'd3) begin failures++; $display("FAIL icw4_done init=%b cur=%0d want 1/3", init_done, wr_cur); end
  endtask

  task automatic test_init_cascade();
    wr_word(1'b0, 8'h11);
    checks++; if ({sngl, ic4, init_done} !== 3'b010) begin failures++; $display("FAIL casc_icw1 got=%b want=010", {sngl, ic4, init_done}); end
    wr_word(1'b1, 8'h20);
    checks++; if (vec_base !== 5'h04 || stb_cyc !== 3) begin failures++; $display("FAIL casc_icw2 vec=%h cyc=%0d want 04/3", vec_base, stb_cyc); end
    wr_word(1'b1, 8'h04);
    checks++; if (icw3 !== 8'h04 || wr_cur !== 3'd2 || stb_cyc !== 3) begin
      failures++; $display("FAIL casc_icw3 icw3=%h cur=%0d cyc=%0d want 04/2/3", icw3, wr_cur, stb_cyc); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL casc_icw3_wait init_done=%b want 0", init_done); end
    wr_word(1'b1, 8'h01);
    checks++; if (init_done !== 1'b1 || aeoi !== 1'b0 || wr_cur !== 3'd3) begin
      failures++; $display("FAIL casc_icw4 init=%b aeoi=%b cur=%0d want 1/0/3", init_done, aeoi, wr_cur); end
    checks++; if (stb_cyc !== 3 || n_wr !== 1) begin failures++; $display("FAIL casc_timing cyc=%0d pulses=%0d want 3/1", stb_cyc, n_wr); end
  endtask

  task automatic test_mask16();
    wr_word(1'b1, 8'hAA);
    checks++; if (imr !== 16'h0000 || n_wr !== 1 || wr_cur !== 3'd4) begin
      failures++; $display("FAIL ocw1_b1 imr=%h pulses=%0d cur=%0d want 0000/1/4", imr, n_wr, wr_cur); end
    wr_word(1'b1, 8'h55);
    checks++; if (imr !== 16'h55AA) begin failures++; $display("FAIL ocw1_b2 imr=%h want=55aa", imr); end
    wr_word(1'b1, 8'hFF);
    checks++; if (imr !== 16'h55AA) begin failures++; $display("FAIL ocw1_staged imr=%h want=55aa", imr); end
    wr_word(1'b0, 8'h20);
    checks++; if (n_o2 !== 1) begin failures++; $display("FAIL ocw2_between pulses=%0d want 1", n_o2); end
    wr_word(1'b1, 8'hFF);
    checks++; if (imr !== 16'h55AA) begin failures++; $display("FAIL ocw1_ptr_reset imr=%h want=55aa", imr); end
    wr_word(1'b1, 8'h00);
    checks++; if (imr !== 16'h00FF) begin failures++; $display("FAIL ocw1_after_reset imr=%h want=00ff", imr); end
  endtask

  task automatic test_page_ocw2();
    // D7 selects the extended page write; D3 is needed for the OCW3 decode.
    wr_word(1'b0, 8'h89);
    checks++; if (wr_cur !== 3'd6 || n_o2 !== 0 || rd_sel !== 2'b10) begin
      failures++; $display("FAIL page_wr cur=%0d o2=%0d rd_sel=%b want 6/0/10", wr_cur, n_o2, rd_sel); end
    wr_word(1'b0, 8'h63);
    checks++; if (ocw2_lvl !== 4'hB || ocw2_cmd !== 3'b011) begin
      failures++; $display("FAIL ocw2_paged lvl=%h cmd=%b want b/011", ocw2_lvl, ocw2_cmd); end
    checks++; if (n_o2 !== 1 || wr_cur !== 3'd5) begin failures++; $display("FAIL ocw2_stb pulses=%0d cur=%0d want 1/5", n_o2, wr_cur); end
  endtask

  task automatic test_ocw3();
    wr_word(1'b0, 8'h0B);
    checks++; if (rd_sel !== 2'b11 || n_poll !== 0) begin failures++; $display("FAIL ocw3_rr rd_sel=%b poll=%0d want 11/0", rd_sel, n_poll); end
    wr_word(1'b0, 8'h0C);
    checks++; if (n_poll !== 1 || rd_sel !== 2'b11) begin failures++; $display("FAIL ocw3_poll poll=%0d rd_sel=%b want 1/11", n_poll, rd_sel); end
    wr_word(1'b0, 8'h68);
    checks++; if (smm !== 1'b1) begin failures++; $display("FAIL ocw3_smm got=%b want 1", smm); end
  endtask

  task automatic test_rd();
    @(negedge clk); cs_n = 1'b0; rd_n = 1'b0; n_rd = 0;
    repeat (6) begin @(posedge clk); #1; if (rd_stb) n_rd++; end
    rd_n = 1'b1; cs_n = 1'b1;
    checks++; if (n_rd !== 1) begin failures++; $display("FAIL rd_sel_low pulses=%0d want 1", n_rd); end
    repeat (3) @(negedge clk);
    rd_n = 1'b0; n_rd = 0;
    repeat (6) begin @(posedge clk); #1; if (rd_stb) n_rd++; end
    rd_n = 1'b1;
    checks++; if (n_rd !== 0) begin failures++; $display("FAIL rd_unselected pulses=%0d want 0", n_rd); end
  endtask

  task automatic test_seq_err();
    do_reset();
    wr_word(1'b0, 8'h20);
    checks++; if (n_err !== 1 || n_wr !== 0 || init_done !== 1'b0 || wr_cur !== 3'd0) begin
      failures++; $display("FAIL err_uninit err=%0d wr=%0d init=%b cur=%0d want 1/0/0/0", n_err, n_wr, init_done, wr_cur); end
    wr_word(1'b0, 8'h13);
    wr_word(1'b0, 8'h0A);
    checks++; if (n_err !== 1 || n_wr !== 0) begin failures++; $display("FAIL err_w_icw2 err=%0d wr=%0d want 1/0", n_err, n_wr); end
    wr_word(1'b1, 8'h48);
    checks++; if (vec_base !== 5'h09 || wr_cur !== 3'd1 || n_err !== 0) begin
      failures++; $display("FAIL err_state_held vec=%h cur=%0d err=%0d want 09/1/0", vec_base, wr_cur, n_err); end
  endtask

  task automatic test_reset_mid();
    wr_word(1'b0, 8'h11);
    wr_word(1'b1, 8'h20);
    @(negedge clk); cs_n = 1'b0; a0 = 1'b1; din = 8'h04; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (imr !== 16'hFFFF || init_done !== 1'b0 || wr_cur !== 3'd0) begin
      failures++; $display("FAIL rst_async imr=%h init=%b cur=%0d want ffff/0/0", imr, init_done, wr_cur); end
    wr_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_word(1'b1, 8'h04);
    checks++; if (n_err !== 1 || n_wr !== 0 || icw3 !== 8'h00) begin
      failures++; $display("FAIL rst_uninit err=%0d wr=%0d icw3=%h want 1/0/00", n_err, n_wr, icw3); end
  endtask

  initial begin
    test_reset();
    test_init_single();
    test_init_cascade();
    test_mask16();
    test_page_ocw2();
    test_ocw3();
    test_rd();
    test_seq_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
